// File: rtl/vga_pkg.sv
// Shared VGA timing constants for the 640x480 @ 60 Hz mode.
// Both vga_timing and the image generator import this package, so the
// frame size they agree on lives in exactly one place.
//   coord_t      : 12-bit unsigned pixel/line coordinate
//   line_total() : sum of visible + porches + sync for one axis
package vga_pkg;

  localparam int unsigned CNT_W = 12;

  typedef logic [CNT_W-1:0] coord_t;

  // Horizontal defaults, in pixels
  localparam int unsigned H_VISIBLE_DEF = 640;
  localparam int unsigned H_FRONT_DEF   = 16;
  localparam int unsigned H_SYNC_DEF    = 96;
  localparam int unsigned H_BACK_DEF    = 48;

  // Vertical defaults, in lines
  localparam int unsigned V_VISIBLE_DEF = 480;
  localparam int unsigned V_FRONT_DEF   = 10;
  localparam int unsigned V_SYNC_DEF    = 2;
  localparam int unsigned V_BACK_DEF    = 33;

  function automatic int unsigned line_total(input int unsigned visible,
                                             input int unsigned front,
                                             input int unsigned sync,
                                             input int unsigned back);
    return visible + front + sync + back;
  endfunction

  localparam int unsigned H_TOTAL_DEF =
    line_total(H_VISIBLE_DEF, H_FRONT_DEF, H_SYNC_DEF, H_BACK_DEF);
  localparam int unsigned V_TOTAL_DEF =
    line_total(V_VISIBLE_DEF, V_FRONT_DEF, V_SYNC_DEF, V_BACK_DEF);

  // Frame dimensions seen by the image generator
  localparam int unsigned FRAME_WIDTH  = H_VISIBLE_DEF;
  localparam int unsigned FRAME_HEIGHT = V_VISIBLE_DEF;

endpackage

// File: rtl/vga_counter.sv
// Wrapping 12-bit up-counter used for both the pixel (x) and line (y) axes.
//   clk     : pixel clock, rising edge
//   rst_n   : synchronous active-low reset, clears the count
//   en      : advance the count this cycle
//   count   : registered current value, 0..WRAP_AT
//   wrap    : high in the cycle the counter is enabled at WRAP_AT, i.e. the
//             cycle whose edge returns the count to zero
module vga_counter
  import vga_pkg::*;
#(
  parameter int unsigned WRAP_AT = H_TOTAL_DEF - 1
) (
  input  logic   clk,
  input  logic   rst_n,
  input  logic   en,
  output coord_t count,
  output logic   wrap
);

  localparam coord_t WRAP_VAL = coord_t'(WRAP_AT);

  coord_t count_q;
  coord_t count_d;

  always_comb begin
    wrap    = en && (count_q == WRAP_VAL);
    count_d = count_q;
    if (en) begin
      count_d = wrap ? '0 : count_q + coord_t'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;

endmodule

// File: rtl/vga_timing.sv
// VGA raster timing generator.
// Scans x across each line and y down each frame, publishes the current
// x,y so an image generator can return a colour combinationally, then
// registers that colour (blanked outside the visible area) together with
// the sync pulses, so every DAC-facing output lags x,y by exactly one cycle.
//   CLOCK_25            : 25 MHz pixel clock
//   RESET_N             : synchronous active-low reset
//   color[2:0]          : {R,G,B} for the current x,y
//   x, y                : current pixel column / line
//   vga_r, vga_g, vga_b : registered colour bits
//   vga_hs, vga_vs      : registered active-low syncs
//   frame_tick          : one-cycle pulse at the start of vertical blanking
module vga_timing
  import vga_pkg::*;
#(
  parameter int unsigned H_VISIBLE = H_VISIBLE_DEF,
  parameter int unsigned H_FRONT   = H_FRONT_DEF,
  parameter int unsigned H_SYNC    = H_SYNC_DEF,
  parameter int unsigned H_BACK    = H_BACK_DEF,
  parameter int unsigned V_VISIBLE = V_VISIBLE_DEF,
  parameter int unsigned V_FRONT   = V_FRONT_DEF,
  parameter int unsigned V_SYNC    = V_SYNC_DEF,
  parameter int unsigned V_BACK    = V_BACK_DEF
) (
  input  logic        CLOCK_25,
  input  logic        RESET_N,
  input  logic [2:0]  color,
  output logic [11:0] x,
  output logic [11:0] y,
  output logic        vga_r,
  output logic        vga_g,
  output logic        vga_b,
  output logic        vga_hs,
  output logic        vga_vs,
  output logic        frame_tick
);

  localparam int unsigned H_TOTAL = line_total(H_VISIBLE, H_FRONT, H_SYNC, H_BACK);
  localparam int unsigned V_TOTAL = line_total(V_VISIBLE, V_FRONT, V_SYNC, V_BACK);

  localparam coord_t H_VIS_END = coord_t'(H_VISIBLE);
  localparam coord_t V_VIS_END = coord_t'(V_VISIBLE);
  localparam coord_t HS_START  = coord_t'(H_VISIBLE + H_FRONT);
  localparam coord_t HS_END    = coord_t'(H_VISIBLE + H_FRONT + H_SYNC);
  localparam coord_t VS_START  = coord_t'(V_VISIBLE + V_FRONT);
  localparam coord_t VS_END    = coord_t'(V_VISIBLE + V_FRONT + V_SYNC);
  localparam coord_t V_LAST_VIS = coord_t'(V_VISIBLE - 1);

  coord_t x_cnt;
  coord_t y_cnt;
  logic   h_wrap;
  logic   v_wrap_unused;

  // The line counter only advances on the cycle the pixel counter wraps,
  // so both counters return to zero on the same edge at the frame end.
  vga_counter #(.WRAP_AT(H_TOTAL - 1)) u_h_counter (
    .clk   (CLOCK_25),
    .rst_n (RESET_N),
    .en    (1'b1),
    .count (x_cnt),
    .wrap  (h_wrap)
  );

  vga_counter #(.WRAP_AT(V_TOTAL - 1)) u_v_counter (
    .clk   (CLOCK_25),
    .rst_n (RESET_N),
    .en    (h_wrap),
    .count (y_cnt),
    .wrap  (v_wrap_unused)
  );

  logic       active;
  logic       hs_raw;
  logic       vs_raw;
  logic [2:0] rgb_d;
  logic [2:0] rgb_q;
  logic       hs_d;
  logic       hs_q;
  logic       vs_d;
  logic       vs_q;
  logic       tick_d;
  logic       tick_q;

  // h_wrap already means x == H_TOTAL-1, so the tick only needs the
  // last-visible-line test on y.
  always_comb begin
    active = (x_cnt < H_VIS_END) && (y_cnt < V_VIS_END);
    hs_raw = !((x_cnt >= HS_START) && (x_cnt < HS_END));
    vs_raw = !((y_cnt >= VS_START) && (y_cnt < VS_END));
    rgb_d  = active ? color : 3'b000;
    hs_d   = hs_raw;
    vs_d   = vs_raw;
    tick_d = h_wrap && (y_cnt == V_LAST_VIS);
  end

  always_ff @(posedge CLOCK_25) begin
    if (!RESET_N) begin
      rgb_q  <= 3'b000;
      hs_q   <= 1'b1;
      vs_q   <= 1'b1;
      tick_q <= 1'b0;
    end else begin
      rgb_q  <= rgb_d;
      hs_q   <= hs_d;
      vs_q   <= vs_d;
      tick_q <= tick_d;
    end
  end

  assign x          = x_cnt;
  assign y          = y_cnt;
  assign vga_r      = rgb_q[2];
  assign vga_g      = rgb_q[1];
  assign vga_b      = rgb_q[0];
  assign vga_hs     = hs_q;
  assign vga_vs     = vs_q;
  assign frame_tick = tick_q;

endmodule

// File: doc/vga_timing.md
VGA_TIMING -- requirements
Module: vga_timing

Interface
REQ-001 SHALL have parameter H_VISIBLE, default 640, active pixels per line.
REQ-002 SHALL have parameter H_FRONT, default 16, horizontal front-porch pixels.
REQ-003 SHALL have parameter H_SYNC, default 96, hsync pulse width in pixels.
REQ-004 SHALL have parameter H_BACK, default 48, horizontal back-porch pixels.
REQ-005 SHALL have parameter V_VISIBLE, default 480, active lines per frame.
REQ-006 SHALL have parameters V_FRONT, V_SYNC and V_BACK, defaults 10, 2 and 33, vertical porch and sync widths in lines.
REQ-007 SHALL use one clock and a synchronous, active-low reset, with ports as follows.
REQ-008 CLOCK_25  input  1  25 MHz pixel clock; all state on its rising edge.
REQ-009 RESET_N  input  1  synchronous active-low reset.
REQ-010 color  input  3  pixel colour {R,G,B} for the current x,y; combinational from the image generator.
REQ-011 x  output  12  current pixel column, 0..H_TOTAL-1.
REQ-012 y  output  12  current line, 0..V_TOTAL-1.
REQ-013 vga_r, vga_g, vga_b  output  1 each  registered colour bits to the DAC.
REQ-014 vga_hs, vga_vs  output  1 each  active-low sync pulses.
REQ-015 frame_tick  output  1  one-cycle pulse at the start of vertical blanking.

Function
REQ-016 H_TOTAL SHALL equal H_VISIBLE+H_FRONT+H_SYNC+H_BACK (800); V_TOTAL SHALL equal V_VISIBLE+V_FRONT+V_SYNC+V_BACK (525).
REQ-017 x SHALL increment by 1 each cycle and wrap from H_TOTAL-1 to 0.
REQ-018 y SHALL increment by 1 only on the cycle x wraps, and SHALL wrap from V_TOTAL-1 to 0 on the same cycle x wraps.
REQ-019 active SHALL equal (x < H_VISIBLE) && (y < V_VISIBLE), computed from the registered x,y.
REQ-020 hs_raw SHALL be low for H_VISIBLE+H_FRONT <= x < H_VISIBLE+H_FRONT+H_SYNC (656..751), else high.
REQ-021 vs_raw SHALL be low for V_VISIBLE+V_FRONT <= y < V_VISIBLE+V_FRONT+V_SYNC (490..491), else high.
REQ-022 Output pipeline SHALL have exactly 1 cycle of latency: at edge N+1, vga_r/g/b SHALL capture color when active, else 0, and vga_hs/vga_vs SHALL capture hs_raw/vs_raw, all from the x,y present in cycle N.
REQ-023 Colour SHALL be forced to 000 for every non-active pixel regardless of the color input.
REQ-024 frame_tick SHALL be registered and high for exactly one cycle: the cycle following x==H_TOTAL-1, y==V_VISIBLE-1.
REQ-025 Counters SHALL use unsigned 12-bit arithmetic; comparisons SHALL never see an out-of-range value.

Reset
REQ-026 While RESET_N is low at a clock edge: x=0, y=0, vga_r/g/b=0, vga_hs=1, vga_vs=1, frame_tick=0.
REQ-027 Reset asserted mid-line or mid-frame SHALL take effect on the next edge; there is no partial-frame recovery.
REQ-028 On the first edge with RESET_N high, counting SHALL resume from x=0, y=0.

Structure
REQ-029 Default timing constants and the derived H_TOTAL/V_TOTAL SHALL live in shared package vga_pkg, which img_generator also uses for frame width/height.
REQ-030 The horizontal and vertical counters SHALL be one sub-module, vga_counter (wrap value as parameter, enable input, wrap output), instantiated twice.
REQ-031 No other sub-modules; the module SHALL contain no latches or combinational loops.

Verification
REQ-032 Reset released at cycle 0 -> x=0,y=0 on the first edge after release; x=799 at cycle 799; x=0,y=1 at cycle 800.
REQ-033 Run one full frame, 420000 cycles -> y wraps 524->0 exactly once; vga_vs low for exactly 2 lines (1600 cycles) per frame.
REQ-034 Hold color=3'b111 -> vga_r/g/b=111 one cycle after x=0..639 with y<480, and 000 for x>=640 or y>=480.
REQ-035 Sample vga_hs per line -> low for exactly 96 cycles, starting one cycle after x=656.
REQ-036 Assert RESET_N low at x=400,y=300 for 3 cycles -> outputs hold their reset values throughout, then counting restarts at x=0,y=0.
REQ-037 Count frame_tick over 3 frames -> exactly 3 one-cycle pulses, each 420000 cycles apart.
